// File: rtl/multi_voice_tone_gen.sv
// multi_voice_tone_gen: VOICES independent square-wave oscillators built on
// phase accumulators. Notes are loaded through a valid/ready write port and
// their durations count down on the VGA frame tick. The voices are summed
// into a registered level, which then drives a 1-bit PWM output.
// Optional build macro: TONE_ENVELOPE_EN adds a per-frame volume decay
// (floor 1). Without it, the volume stays fixed for the life of a note.
module multi_voice_tone_gen #(
  parameter int VOICES = 3,
  parameter int ACC_W  = 16,
  parameter int VOL_W  = 2,
  parameter int DUR_W  = 4,
  localparam int VI_W  = (VOICES > 1) ? $clog2(VOICES) : 1,
  localparam int LVL_W = VOL_W + $clog2(VOICES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              frame_tick,
  input  logic              note_wr,
  output logic              note_ready,
  input  logic [VI_W-1:0]   note_voice,
  input  logic [ACC_W-1:0]  note_inc,
  input  logic [VOL_W-1:0]  note_vol,
  input  logic [DUR_W-1:0]  note_dur,
  output logic [VOICES-1:0] voice_active,
  output logic [LVL_W-1:0]  audio_level,
  output logic              audio_pwm
);

  logic [ACC_W-1:0]  acc_reg [VOICES];
  logic [ACC_W-1:0]  inc_reg [VOICES];
  logic [VOL_W-1:0]  vol_reg [VOICES];
  logic [DUR_W-1:0]  dur_reg [VOICES];
  logic [VOICES-1:0] active_reg;
  logic              ready_reg;
  logic [LVL_W-1:0]  pwm_cnt_reg;
  logic [LVL_W-1:0]  level_reg;
  logic              pwm_reg;

  logic              accept;
  logic [LVL_W-1:0]  contrib [VOICES];
  logic [LVL_W-1:0]  sum_next;

  assign accept       = note_wr && ready_reg;
  assign note_ready   = ready_reg;
  assign voice_active = active_reg;
  assign audio_level  = level_reg;
  assign audio_pwm    = pwm_reg;

  // A voice adds its volume while it is active and its square wave is high.
  for (genvar gi = 0; gi < VOICES; gi++) begin : gen_contrib
    assign contrib[gi] = (active_reg[gi] && acc_reg[gi][ACC_W-1]) ?
                         LVL_W'(vol_reg[gi]) : '0;
  end

  // The mixer sums all voice contributions. The chosen LVL_W is wide enough
  // that the full-scale sum cannot overflow.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < VOICES; i++) begin
      sum_next = sum_next + contrib[i];
    end
  end

  // The load stage drops ready for one cycle after each accepted write.
  always_ff @(posedge clk) begin
    if (!rst_n) ready_reg <= 1'b1;
    else        ready_reg <= !accept;
  end

  // Per-voice state. A write to the voice overrides the oscillator and any
  // frame processing in the same cycle. A voice that runs out of frames
  // returns its accumulator to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        acc_reg[i] <= '0;
        inc_reg[i] <= '0;
        vol_reg[i] <= '0;
        dur_reg[i] <= '0;
      end
      active_reg <= '0;
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (accept && (int'(note_voice) == i)) begin
          inc_reg[i]    <= note_inc;
          vol_reg[i]    <= note_vol;
          dur_reg[i]    <= note_dur;
          acc_reg[i]    <= '0;
          active_reg[i] <= (note_dur != '0);
        end else if (ena && active_reg[i]) begin
          if (frame_tick) begin
`ifdef TONE_ENVELOPE_EN
            if (vol_reg[i] > VOL_W'(1)) vol_reg[i] <= vol_reg[i] - VOL_W'(1);
`endif
            if (dur_reg[i] == DUR_W'(1)) begin
              dur_reg[i]    <= '0;
              active_reg[i] <= 1'b0;
              acc_reg[i]    <= '0;
            end else begin
              dur_reg[i] <= dur_reg[i] - DUR_W'(1);
              acc_reg[i] <= acc_reg[i] + inc_reg[i];
            end
          end else begin
            acc_reg[i] <= acc_reg[i] + inc_reg[i];
          end
        end
      end
    end
  end

  // Registered mix level, plus a PWM stage that compares a free-running
  // counter against that level. The PWM stage is silenced while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_reg   <= '0;
      pwm_cnt_reg <= '0;
      pwm_reg     <= 1'b0;
    end else begin
      level_reg <= sum_next;
      pwm_reg   <= ena && (pwm_cnt_reg < level_reg);
      if (ena) pwm_cnt_reg <= pwm_cnt_reg + LVL_W'(1);
    end
  end

endmodule
